bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 64, cycles a granted requester keeps the bus while the other requester waits; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  bus requests from external masters (bit0 = DMA, bit1 = debug), active-high, level-held until done.
REQ-005 gnt  output  2  one-hot-or-zero grant to masters, registered.
REQ-006 cpu_busrq_n  output  1  bus request to the CPU core, active-low, registered.
REQ-007 cpu_busack_n  input  1  CPU bus release acknowledge, active-low, same clock domain, sampled directly.
REQ-008 preempt  output  1  one-cycle pulse when a grant is withdrawn by the hold limit.

Function
REQ-009 FSM states IDLE, REQ, GRANT, HANDOVER, RELEASE; state encoding is free.
REQ-010 IDLE: when any req bit is set, select a winner, drive cpu_busrq_n=0 next cycle, go to REQ.
REQ-011 Arbitration is round-robin: with both bits set, the master not granted last wins; with one bit set, that master wins.
REQ-012 REQ: hold cpu_busrq_n=0; on cpu_busack_n=0 sampled, assert gnt[winner] next cycle and go to GRANT.
REQ-013 REQ with the winner's req dropped before ack: go to RELEASE, cpu_busrq_n=1; gnt stays 0.
REQ-014 GRANT: gnt[owner]=1, cpu_busrq_n=0; hold counter increments each cycle while the other req bit is set, else clears to 0.
REQ-015 GRANT, owner req drops, other req set: go to HANDOVER; the CPU bus is not returned.
REQ-016 GRANT, owner req drops, other req clear: go to RELEASE.
REQ-017 HANDOVER: gnt=0 for exactly one cycle, cpu_busrq_n stays 0, owner switches to the other master, then GRANT.
REQ-018 HANDOVER where the new owner's req has dropped: go to RELEASE instead of GRANT.
REQ-019 RELEASE: gnt=0, cpu_busrq_n=1; once cpu_busack_n=1 is sampled, go to IDLE; no new request is raised before this.
REQ-020 cpu_busack_n rising during GRANT or HANDOVER (CPU reclaimed the bus): gnt=0 next cycle, go to REQ with the same owner; cpu_busrq_n stays 0.
REQ-021 gnt never has both bits set, and gnt is never nonzero unless cpu_busack_n was 0 on the previous sample.
REQ-022 The last-granted pointer updates on every GRANT entry.

Reset
REQ-023 rst asserted: immediately go to IDLE, gnt=2'b00, cpu_busrq_n=1, preempt=0, hold counter=0, last-granted pointer=1, so master 0 wins the first tie.
REQ-024 Reset mid-transfer drops gnt asynchronously, with no HANDOVER or RELEASE sequencing.
REQ-025 The first arbitration is evaluated on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro BUS_ARBITER_HOLD_LIMIT_EN defined: in GRANT with the other req set and hold counter = HOLD_MAX-1, go to HANDOVER and pulse preempt for 1 cycle.
REQ-027 Macro BUS_ARBITER_HOLD_LIMIT_EN undefined: no preemption; the owner keeps the bus until its req drops; preempt is tied 0; the counter may be removed.

Verification
REQ-028 req=01 at cycle 0, busack_n low 3 cycles after busrq_n falls -> busrq_n=0 at cycle 1, gnt=01 one cycle after ack sampled.
REQ-029 req=11 from reset -> gnt=01 first; req0 drops -> gnt=00 for 1 cycle, then gnt=10 with busrq_n held 0 throughout.
REQ-030 Macro defined, HOLD_MAX=4, req=11 held -> gnt alternates 01/00/10/00/..., each grant lasts 4 cycles, preempt pulses at each switch.
REQ-031 Macro undefined, req=11 held 100 cycles -> gnt=01 for all 100 cycles, preempt always 0.
REQ-032 req0 withdrawn while in REQ before ack -> busrq_n=1 next cycle, gnt never asserted, IDLE after busack_n returns high.
REQ-033 rst pulsed while gnt=10 -> gnt=00 and busrq_n=1 without waiting for a clock edge; next tie goes to master 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Borrows the CPU bus on behalf of two external masters (bit0 = DMA,
// bit1 = debug). The arbiter raises cpu_busrq_n, waits for cpu_busack_n and
// then grants one master at a time. Masters that request together are served
// round-robin. The bus passes directly between masters through HANDOVER,
// without returning it to the CPU.
//
// Optional feature: define BUS_ARBITER_HOLD_LIMIT_EN to enable preemption.
// With preemption, a master keeps the bus for at most HOLD_MAX cycles while
// the other master waits. When the limit ends a grant, preempt pulses high.
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int HOLD_MAX = 64  // legal range 2..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       cpu_busrq_n,
    input  logic       cpu_busack_n,
    output logic       preempt
);

    // The counter only needs to reach HOLD_MAX-1, where the hold limit fires.
    localparam int               CNT_W     = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_HANDOVER,
        S_RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_owner;         // master currently served (0 = DMA, 1 = debug)
    logic             w_next_owner;
    logic             r_last;          // master granted most recently, for round-robin
    logic             w_next_last;
    logic [CNT_W-1:0] r_hold_cnt;      // grant cycles spent while the other master waits
    logic [CNT_W-1:0] w_next_hold_cnt;
    logic [1:0]       r_gnt;
    logic [1:0]       w_next_gnt;
    logic             r_busrq_n;
    logic             w_next_busrq_n;
    logic             r_preempt;
    logic             w_next_preempt;

    logic             w_owner_req;
    logic             w_other_req;
    logic             w_hold_expired;

    assign w_owner_req = req[r_owner];
    assign w_other_req = req[~r_owner];

`ifdef BUS_ARBITER_HOLD_LIMIT_EN
    assign w_hold_expired = w_other_req && (r_hold_cnt == HOLD_LAST);
`else
    assign w_hold_expired = 1'b0;
`endif

    // Next-state, owner and last-granted selection.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one
        // unassigned and infer a latch.
        w_next_state   = r_state;
        w_next_owner   = r_owner;
        w_next_last    = r_last;
        w_next_preempt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_next_state = S_REQ;
                    // On a tie, the master not granted last wins.
                    w_next_owner = (req == 2'b11) ? ~r_last : req[1];
                end
            end
            S_REQ: begin
                if (!w_owner_req) begin
                    w_next_state = S_RELEASE;
                end else if (!cpu_busack_n) begin
                    w_next_state = S_GRANT;
                    w_next_last  = r_owner;
                end
            end
            S_GRANT: begin
                if (cpu_busack_n) begin
                    // The CPU took the bus back; ask again for the same owner.
                    w_next_state = S_REQ;
                end else if (!w_owner_req) begin
                    if (w_other_req) begin
                        w_next_state = S_HANDOVER;
                        w_next_owner = ~r_owner;
                    end else begin
                        w_next_state = S_RELEASE;
                    end
                end else if (w_hold_expired) begin
                    w_next_state   = S_HANDOVER;
                    w_next_owner   = ~r_owner;
                    w_next_preempt = 1'b1;
                end
            end
            S_HANDOVER: begin
                if (!w_owner_req) begin
                    w_next_state = S_RELEASE;
                end else if (cpu_busack_n) begin
                    w_next_state = S_REQ;
                end else begin
                    w_next_state = S_GRANT;
                    w_next_last  = r_owner;
                end
            end
            S_RELEASE: begin
                if (cpu_busack_n) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Hold counter: counts while the grant continues and the other master waits, else clears.
    always_comb begin
        w_next_hold_cnt = '0;
        if ((r_state == S_GRANT) && (w_next_state == S_GRANT) && w_other_req) begin
            w_next_hold_cnt = (r_hold_cnt == HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
    end

    // Output values for the next cycle, decoded from the next state so outputs can be registered.
    always_comb begin
        w_next_gnt     = 2'b00;
        w_next_busrq_n = 1'b1;
        if (w_next_state == S_GRANT) begin
            w_next_gnt = w_next_owner ? 2'b10 : 2'b01;
        end
        if (w_next_state inside {S_REQ, S_GRANT, S_HANDOVER}) begin
            w_next_busrq_n = 1'b0;
        end
    end

    // State and output registers; reset drops the grant without any sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
            r_gnt      <= 2'b00;
            r_busrq_n  <= 1'b1;
            r_preempt  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, independent of statement order.
            r_state    <= w_next_state;
            r_owner    <= w_next_owner;
            r_last     <= w_next_last;
            r_hold_cnt <= w_next_hold_cnt;
            r_gnt      <= w_next_gnt;
            r_busrq_n  <= w_next_busrq_n;
            r_preempt  <= w_next_preempt;
        end
    end

    assign gnt         = r_gnt;
    assign cpu_busrq_n = r_busrq_n;
    assign preempt     = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed scenarios plus randomized request/acknowledge traffic for
// bus_arbiter. A transaction-level reference model tracks who holds the
// borrowed bus and predicts gnt, cpu_busrq_n and preempt every cycle.
// If BUS_ARBITER_HOLD_LIMIT_EN is defined, the model also applies the hold limit.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TB_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       cpu_busrq_n;
    logic       cpu_busack_n;
    logic       preempt;

    int n_vec = 0;
    int n_err = 0;

    bus_arbiter #(.HOLD_MAX(TB_HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .cpu_busrq_n  (cpu_busrq_n),
        .cpu_busack_n (cpu_busack_n),
        .preempt      (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_ask     : the arbiter is asking the CPU for the bus (busrq active)
    // m_granted : a master is using the bus
    // m_gap     : dead cycle between two masters
    // m_drain   : bus being returned, waiting for the CPU to take it back
    bit m_ask, m_granted, m_gap, m_drain;
    bit m_owner, m_last, m_pre;
    int m_tenure;   // consecutive granted edges with the other master waiting

    task automatic model_reset();
        m_ask     = 1'b0;
        m_granted = 1'b0;
        m_gap     = 1'b0;
        m_drain   = 1'b0;
        m_owner   = 1'b0;
        m_last    = 1'b1;
        m_pre     = 1'b0;
        m_tenure  = 0;
    endtask

    task automatic give_back();
        m_ask     = 1'b0;
        m_granted = 1'b0;
        m_drain   = 1'b1;
        m_tenure  = 0;
    endtask

    task automatic model_step(input logic [1:0] r, input logic ack_n);
        bit other;
        m_pre = 1'b0;
        if (m_drain) begin
            if (ack_n) m_drain = 1'b0;
        end else if (!m_ask) begin
            if (r != 2'b00) begin
                m_ask   = 1'b1;
                m_owner = (r == 2'b11) ? !m_last : r[1];
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            if (!r[m_owner]) give_back();
            else if (!ack_n) begin
                m_granted = 1'b1;
                m_last    = m_owner;
                m_tenure  = 0;
            end
        end else if (m_granted) begin
            other = r[!m_owner];
            if (ack_n) begin
                m_granted = 1'b0;
                m_tenure  = 0;
            end else if (!r[m_owner]) begin
                if (other) begin
                    m_granted = 1'b0;
                    m_gap     = 1'b1;
                    m_owner   = !m_owner;
                    m_tenure  = 0;
                end else begin
                    give_back();
                end
            end else begin
                m_tenure = other ? m_tenure + 1 : 0;
`ifdef BUS_ARBITER_HOLD_LIMIT_EN
                if (m_tenure >= TB_HOLD) begin
                    m_granted = 1'b0;
                    m_gap     = 1'b1;
                    m_owner   = !m_owner;
                    m_pre     = 1'b1;
                    m_tenure  = 0;
                end
`endif
            end
        end else begin
            if (!r[m_owner]) give_back();
            else if (!ack_n) begin
                m_granted = 1'b1;
                m_last    = m_owner;
                m_tenure  = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1 ns later.
    task automatic cycle(input logic [1:0] r, input logic a);
        logic [1:0] exp_gnt;
        req          = r;
        cpu_busack_n = a;
        @(posedge clk);
        model_step(r, a);
        #1;
        exp_gnt = m_granted ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check("gnt", {30'd0, gnt}, {30'd0, exp_gnt});
        check("busrq_n", {31'd0, cpu_busrq_n}, {31'd0, !m_ask});
        check("preempt", {31'd0, preempt}, {31'd0, m_pre});
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req          = 2'b00;
        cpu_busack_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_busrq_n", {31'd0, cpu_busrq_n}, 32'd1);
        check("rst_preempt", {31'd0, preempt}, 32'd0);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         n_hold;
        int         n_pre;
        logic [1:0] r_s;
        logic       a_s;

        rst          = 1'b1;
        req          = 2'b00;
        cpu_busack_n = 1'b1;
        @(posedge clk);
        do_reset();

        // Single DMA request, CPU acknowledges three cycles after busrq falls.
        cycle(2'b01, 1'b1);
        check("t028_busrq_c1", {31'd0, cpu_busrq_n}, 32'd0);
        cycle(2'b01, 1'b1);
        cycle(2'b01, 1'b1);
        cycle(2'b01, 1'b0);
        check("t028_gnt", {30'd0, gnt}, 32'd1);
        cycle(2'b01, 1'b0);
        cycle(2'b00, 1'b0);
        check("t028_release", {31'd0, cpu_busrq_n}, 32'd1);
        cycle(2'b00, 1'b1);
        cycle(2'b00, 1'b1);

        // Tie from reset, then handover to the debug master.
        do_reset();
        cycle(2'b11, 1'b1);
        cycle(2'b11, 1'b0);
        check("t029_first", {30'd0, gnt}, 32'd1);
        cycle(2'b11, 1'b0);
        cycle(2'b11, 1'b0);
        cycle(2'b10, 1'b0);
        check("t029_gap_gnt", {30'd0, gnt}, 32'd0);
        check("t029_gap_busrq", {31'd0, cpu_busrq_n}, 32'd0);
        cycle(2'b10, 1'b0);
        check("t029_second", {30'd0, gnt}, 32'd2);
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b1);

        // Request withdrawn before the CPU acknowledges.
        cycle(2'b01, 1'b1);
        cycle(2'b01, 1'b1);
        cycle(2'b00, 1'b1);
        check("t032_busrq", {31'd0, cpu_busrq_n}, 32'd1);
        cycle(2'b00, 1'b1);

        // Asynchronous reset while debug holds the bus.
        cycle(2'b10, 1'b1);
        cycle(2'b10, 1'b0);
        check("t033_pre_gnt", {30'd0, gnt}, 32'd2);
        #3 rst = 1'b1;
        #1;
        check("t033_async_gnt", {30'd0, gnt}, 32'd0);
        check("t033_async_busrq", {31'd0, cpu_busrq_n}, 32'd1);
        do_reset();
        cycle(2'b11, 1'b1);
        cycle(2'b11, 1'b0);
        check("t033_tie", {30'd0, gnt}, 32'd1);

        // Both masters hold their requests for 100 cycles.
        n_hold = 0;
        n_pre  = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(2'b11, 1'b0);
            if (gnt == 2'b01 && !preempt) n_hold++;
            if (preempt) n_pre++;
        end
`ifdef BUS_ARBITER_HOLD_LIMIT_EN
        check("t030_preempts", n_pre, 20);
`else
        check("t031_hold", n_hold, 100);
        check("t031_preempt", n_pre, 0);
`endif
        cycle(2'b00, 1'b0);
        cycle(2'b00, 1'b1);

        // Random traffic with a loosely cooperative CPU that sometimes reclaims the bus.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                r_s = req;
                a_s = cpu_busack_n;
                if ($urandom_range(7) == 0) r_s[0] = ~r_s[0];
                if ($urandom_range(7) == 0) r_s[1] = ~r_s[1];
                if (!cpu_busrq_n) begin
                    if (a_s && $urandom_range(2) == 0) a_s = 1'b0;
                    else if (!a_s && $urandom_range(24) == 0) a_s = 1'b1;
                end else if (!a_s && $urandom_range(1) == 0) begin
                    a_s = 1'b1;
                end
                cycle(r_s, a_s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
